// File: rtl/led_sequencer_if.sv
// Host register bus for the LED sequencer: single-cycle read/write strobes with a one-cycle ack.
// Ports: reg_addr/reg_wdata/reg_we/reg_re driven by the host, reg_rdata/reg_ack returned by the sequencer.
// The host drives the master modport and the sequencer uses the slave modport.
interface led_sequencer_if;
  logic [2:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       reg_ack;

  modport master (
    output reg_addr, reg_wdata, reg_we, reg_re,
    input  reg_rdata, reg_ack
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_we, reg_re,
    output reg_rdata, reg_ack
  );
endinterface

// File: rtl/led_sequencer.sv
// Register-programmable 5-LED sequencer (off / rotate / static / blink) stepped by a tick divider and step period.
// Ports: clk, rst (async active-high), bus (led_sequencer_if.slave register bus), led (registered LED drive).
// Optional LED_SEQUENCER_PWM_EN adds register 5 BRIGHT and a 4-bit PWM gate on led in the output register stage.
module led_sequencer #(
  parameter int TICK_DIV = 120000,
  parameter int NUM_LEDS = 5
) (
  input  logic                clk,
  input  logic                rst,
  led_sequencer_if.slave      bus,
  output logic [NUM_LEDS-1:0] led
);

  localparam int TW = 20;

  typedef enum logic [1:0] {
    M_OFF    = 2'b00,
    M_ROTATE = 2'b01,
    M_STATIC = 2'b10,
    M_BLINK  = 2'b11
  } mode_t;

  mode_t               mode_q, mode_d;
  logic                restart;
  logic                dir_q;
  logic [NUM_LEDS-1:0] pattern_q;
  logic [15:0]         period_q;
  logic [NUM_LEDS-1:0] pos_q;
  logic                blink_off_q;   // 0 = blink phase on, 1 = blink phase off
  logic [TW-1:0]       tick_cnt_q;
  logic [15:0]         step_cnt_q;
  logic [NUM_LEDS-1:0] seq_led_q;
  logic [NUM_LEDS-1:0] seq_led_d;
  logic [NUM_LEDS-1:0] led_q;
  logic                ack_q;
  logic [7:0]          rdata_q;
  logic [7:0]          rd_mux;

  logic                wr_en, rd_en, ctrl_wr, tick, step;
  logic [15:0]         period_eff;

`ifdef LED_SEQUENCER_PWM_EN
  logic [3:0]          bright_q;
  logic [3:0]          pwm_cnt_q;
  logic                pwm_on;
`endif

  // A simultaneous read and write is treated as a write only.
  assign wr_en   = bus.reg_we;
  assign rd_en   = bus.reg_re & ~bus.reg_we;
  assign ctrl_wr = wr_en && (bus.reg_addr == 3'd0);

  assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign period_eff = (period_q == 16'd0) ? 16'd1 : period_q;
  assign step       = tick && (({1'b0, step_cnt_q} + 17'd1) >= {1'b0, period_eff});

  // Mode FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode_q <= M_OFF;
    else     mode_q <= mode_d;
  end

  // Mode FSM: next state and sequencer LED value from current registered state
  always_comb begin
    mode_d    = mode_q;
    restart   = 1'b0;
    seq_led_d = '0;
    if (ctrl_wr && (bus.reg_wdata[1:0] != mode_q)) begin
      mode_d  = mode_t'(bus.reg_wdata[1:0]);
      restart = 1'b1;
    end
    case (mode_q)
      M_OFF:    seq_led_d = '0;
      M_ROTATE: seq_led_d = pos_q;
      M_STATIC: seq_led_d = pattern_q;
      M_BLINK:  seq_led_d = blink_off_q ? '0 : pattern_q;
      default:  seq_led_d = '0;
    endcase
  end

  // Tick divider is free-running; a mode change does not disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else tick_cnt_q <= tick_cnt_q + TW'(1);
  end

  // Step counter, rotation position and blink phase. A mode change restarts
  // the sequence and discards any step landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt_q  <= '0;
      pos_q       <= NUM_LEDS'(1);
      blink_off_q <= 1'b0;
    end else if (restart) begin
      step_cnt_q  <= '0;
      pos_q       <= NUM_LEDS'(1);
      blink_off_q <= 1'b0;
    end else begin
      if (tick) step_cnt_q <= step ? 16'd0 : step_cnt_q + 16'd1;
      if (step && mode_q == M_ROTATE) begin
        if (dir_q) pos_q <= {pos_q[0], pos_q[NUM_LEDS-1:1]};
        else       pos_q <= {pos_q[NUM_LEDS-2:0], pos_q[NUM_LEDS-1]};
      end
      if (step && mode_q == M_BLINK) blink_off_q <= ~blink_off_q;
    end
  end

  // Host-writable configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q     <= 1'b0;
      pattern_q <= NUM_LEDS'(1);
      period_q  <= 16'h01F4;
`ifdef LED_SEQUENCER_PWM_EN
      bright_q  <= 4'hF;
`endif
    end else if (wr_en) begin
      case (bus.reg_addr)
        3'd0: dir_q           <= bus.reg_wdata[2];
        3'd1: pattern_q       <= bus.reg_wdata[NUM_LEDS-1:0];
        3'd2: period_q[7:0]   <= bus.reg_wdata;
        3'd3: period_q[15:8]  <= bus.reg_wdata;
`ifdef LED_SEQUENCER_PWM_EN
        3'd5: bright_q        <= bus.reg_wdata[3:0];
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (bus.reg_addr)
      3'd0: rd_mux = {5'b0, dir_q, mode_q};
      3'd1: rd_mux = {3'b0, pattern_q};
      3'd2: rd_mux = period_q[7:0];
      3'd3: rd_mux = period_q[15:8];
      3'd4: rd_mux = {blink_off_q, mode_q, seq_led_q};
`ifdef LED_SEQUENCER_PWM_EN
      3'd5: rd_mux = {4'b0, bright_q};
`endif
      default: rd_mux = 8'h00;
    endcase
  end

  // Ack for every strobe; read data only moves on a pure read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      ack_q <= bus.reg_we | bus.reg_re;
      if (rd_en) rdata_q <= rd_mux;
    end
  end

`ifdef LED_SEQUENCER_PWM_EN
  assign pwm_on = (pwm_cnt_q < bright_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt_q <= 4'd0;
    else     pwm_cnt_q <= pwm_cnt_q + 4'd1;
  end
`endif

  // Output register; the PWM gate is applied in this same stage so it adds no latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_led_q <= '0;
      led_q     <= '0;
    end else begin
      seq_led_q <= seq_led_d;
`ifdef LED_SEQUENCER_PWM_EN
      led_q     <= seq_led_d & {NUM_LEDS{pwm_on}};
`else
      led_q     <= seq_led_d;
`endif
    end
  end

  assign led           = led_q;
  assign bus.reg_ack   = ack_q;
  assign bus.reg_rdata = rdata_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed self-checking bench for led_sequencer with a short tick divider.
// Ports: drives the register bus through led_sequencer_if and observes led.
// Outputs are sampled 1 time unit after the rising edge.
module tb_led_sequencer;
  logic       clk;
  logic       rst;
  logic [4:0] led;
  int         errors;
  int         checks;

  led_sequencer_if bus();

  led_sequencer #(.TICK_DIV(4), .NUM_LEDS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .led (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns one edge after the ack edge is sampled (i.e. at ack_edge + 1).
  task automatic bus_write(input logic [2:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    bus.reg_addr  = addr;
    bus.reg_wdata = data;
    bus.reg_we    = 1'b1;
    @(posedge clk); #1;
    bus.reg_we    = 1'b0;
    check("wr_ack", {7'b0, bus.reg_ack}, 8'h01);
  endtask

  task automatic bus_read(input string tag, input logic [2:0] addr, input logic [7:0] exp);
    @(posedge clk); #1;
    bus.reg_addr = addr;
    bus.reg_re   = 1'b1;
    @(posedge clk); #1;
    bus.reg_re   = 1'b0;
    check({tag, "_ack"}, {7'b0, bus.reg_ack}, 8'h01);
    check(tag, bus.reg_rdata, exp);
    @(posedge clk); #1;
    check({tag, "_ack_low"}, {7'b0, bus.reg_ack}, 8'h00);
  endtask

  task automatic step_led(input string tag, input logic [7:0] exp, input int exp_cyc);
    logic [4:0] prev;
    int cyc;
    prev = led;
    cyc  = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (led !== prev) break;
    end
    if (led === prev) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout: led stuck at %h", tag, led);
    end else begin
      check(tag, {3'b0, led}, exp);
      if (exp_cyc > 0) check({tag, "_interval"}, 8'(cyc), 8'(exp_cyc));
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.reg_addr  = 3'd0;
    bus.reg_wdata = 8'h00;
    bus.reg_we    = 1'b0;
    bus.reg_re    = 1'b0;
    #22 rst = 1'b0;

    // Reset values
    check("rst_led", {3'b0, led}, 8'h00);
    check("rst_ack", {7'b0, bus.reg_ack}, 8'h00);
    bus_read("rst_status", 3'd4, 8'h00);
    bus_read("rst_pattern", 3'd1, 8'h01);
    bus_read("rst_period_lo", 3'd2, 8'hF4);
    bus_read("rst_period_hi", 3'd3, 8'h01);
    bus_read("rst_ctrl", 3'd0, 8'h00);

    // Rotate left, 2 ticks of 4 clk per step
    bus_write(3'd2, 8'h02);
    bus_write(3'd3, 8'h00);
    bus_write(3'd0, 8'h01);
    @(posedge clk); #1;
    check("rotl_first", {3'b0, led}, 8'h01);
    step_led("rotl_02", 8'h02, 0);
    step_led("rotl_04", 8'h04, 8);
    step_led("rotl_08", 8'h08, 8);
    step_led("rotl_10", 8'h10, 8);
    step_led("rotl_01", 8'h01, 8);

    // Off, then rotate right from a fresh position
    bus_write(3'd0, 8'h00);
    @(posedge clk); #1;
    check("off_led", {3'b0, led}, 8'h00);
    bus_write(3'd0, 8'h05);
    @(posedge clk); #1;
    check("rotr_first", {3'b0, led}, 8'h01);
    step_led("rotr_10", 8'h10, 0);
    step_led("rotr_08", 8'h08, 8);
    step_led("rotr_04", 8'h04, 8);

    // Direction-only change keeps the position
    bus_write(3'd0, 8'h01);
    step_led("dir_08", 8'h08, 0);
    step_led("dir_10", 8'h10, 8);

    // Blink with a step every tick
    bus_write(3'd1, 8'h15);
    bus_write(3'd2, 8'h01);
    bus_write(3'd0, 8'h03);
    @(posedge clk); #1;
    check("blink_first", {3'b0, led}, 8'h15);
    step_led("blink_off1", 8'h00, 0);
    step_led("blink_on", 8'h15, 4);
    step_led("blink_off2", 8'h00, 4);

    // Static mode, simultaneous write/read, unused addresses
    bus_write(3'd0, 8'h02);
    @(posedge clk); #1;
    check("static_led", {3'b0, led}, 8'h15);
    bus_read("pat_rd", 3'd1, 8'h15);
    @(posedge clk); #1;
    bus.reg_addr  = 3'd1;
    bus.reg_wdata = 8'h0A;
    bus.reg_we    = 1'b1;
    bus.reg_re    = 1'b1;
    @(posedge clk); #1;
    bus.reg_we    = 1'b0;
    bus.reg_re    = 1'b0;
    check("wr_rd_ack", {7'b0, bus.reg_ack}, 8'h01);
    check("wr_rd_rdata_held", bus.reg_rdata, 8'h15);
    @(posedge clk); #1;
    check("wr_rd_single_ack", {7'b0, bus.reg_ack}, 8'h00);
    check("wr_rd_led", {3'b0, led}, 8'h0A);
    bus_read("wr_rd_pattern", 3'd1, 8'h0A);
    bus_read("static_status", 3'd4, 8'h4A);
    bus_write(3'd6, 8'h55);
    bus_read("addr6", 3'd6, 8'h00);

    // Pattern change reaches led one cycle after the write lands
    bus_write(3'd1, 8'h11);
    check("pat_lat_old", {3'b0, led}, 8'h0A);
    @(posedge clk); #1;
    check("pat_lat_new", {3'b0, led}, 8'h11);
    bus_write(3'd0, 8'hFE);
    bus_read("ctrl_mask", 3'd0, 8'h06);

`ifdef LED_SEQUENCER_PWM_EN
    begin
      int on_cnt;
      bus_write(3'd1, 8'h1F);
      bus_write(3'd5, 8'h04);
      bus_read("bright_rd", 3'd5, 8'h04);
      on_cnt = 0;
      for (int i = 0; i < 32; i++) begin
        @(posedge clk); #1;
        if (led === 5'h1F) on_cnt++;
      end
      check("pwm_duty", 8'(on_cnt), 8'd8);
    end
`else
    bus_write(3'd5, 8'h07);
    bus_read("addr5", 3'd5, 8'h00);
`endif

    // Asynchronous reset mid-rotation
    bus_write(3'd2, 8'h02);
    bus_write(3'd0, 8'h01);
    @(posedge clk); #1;
    check("pre_rst_first", {3'b0, led}, 8'h01);
    step_led("pre_rst_02", 8'h02, 0);
    step_led("pre_rst_04", 8'h04, 8);
    rst = 1'b1;
    #1;
    check("async_rst_led", {3'b0, led}, 8'h00);
    #2 rst = 1'b0;
    bus_read("post_rst_ctrl", 3'd0, 8'h00);
    bus_read("post_rst_pattern", 3'd1, 8'h01);
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_led", {3'b0, led}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Register-programmable controller that sequences the 5-LED bank on the 120 MHz PLL clock domain.
- Replaces the free-running rotator with four selectable modes: off, rotate, static and blink.
- Host side is a simple single-cycle register bus, intended to be driven by the I2C slave's register port.
- Step timing is derived from a fixed-rate tick divider and a host-programmable step period.

Parameters:
TICK_DIV, 120000, clk cycles per base tick (1 kHz at 120 MHz); legal range 2..2^20
NUM_LEDS, 5, LED count; fixed at 5 for this build

Ports:
clk  input  1  system clock (120 MHz PLL global output)
rst  input  1  asynchronous reset, active-high
reg_addr  input  3  register address
reg_wdata  input  8  write data
reg_we  input  1  write strobe, one-cycle pulse
reg_re  input  1  read strobe, one-cycle pulse
reg_rdata  output  8  read data, valid while reg_ack=1
reg_ack  output  1  one-cycle acknowledge
led  output  5  registered LED drive

Behaviour:
- Reset (async assert, sync release) sets: led=0, reg_ack=0, reg_rdata=0, CTRL=0x00, PATTERN=0x01, PERIOD=0x01F4, pos=5'b00001, blink phase=on, all counters=0.
- Register map:
  - 0 CTRL (rw): [1:0] mode: 00 OFF, 01 ROTATE, 10 STATIC, 11 BLINK; [2] dir (0=left, 1=right); [7:3] read as 0.
  - 1 PATTERN (rw): [4:0].
  - 2 PERIOD_LO (rw).
  - 3 PERIOD_HI (rw).
  - 4 STATUS (ro): [4:0]=led, [6:5]=mode, [7]=blink phase.
  - 5..7: writes ignored, reads return 0.
- Bus handshake:
  - reg_ack pulses exactly one cycle, in the cycle after reg_we or reg_re.
  - reg_rdata is updated in that same cycle and holds until the next read.
  - If reg_we and reg_re are asserted together, the write wins; one ack is issued and reg_rdata is unchanged.
  - Write data takes effect on the clock edge that sets reg_ack.
- Tick counter:
  - Counts 0..TICK_DIV-1.
  - tick=1 for the single cycle when the counter wraps to 0.
- Step counter (16 bit):
  - Increments on each tick.
  - When count+1 >= PERIOD: step=1 for that cycle and the count clears.
  - PERIOD=0 is treated as 1, giving a step every tick.
- Mode FSM, with led updated on the edge after each event:
  - OFF: led=0; counters keep running.
  - ROTATE:
    - led=pos.
    - On step with dir=0: pos rotates left, bit4 wraps to bit0.
    - On step with dir=1: pos rotates right, bit0 wraps to bit4.
  - STATIC: led=PATTERN, which tracks PATTERN writes with 1-cycle latency.
  - BLINK: led=PATTERN while phase=on, 0 while phase=off; phase toggles on each step.
- Mode change (a CTRL write whose mode differs from the current mode):
  - Reset pos=00001, phase=on and step count=0; the tick counter is not reset.
  - led shows the new mode's first value on the following cycle.
- A dir-only change keeps pos; the next step moves in the new direction.
- A PERIOD write mid-count takes effect at the next tick comparison.
  - If the step count is already >= the new PERIOD-1, the step fires on the next tick.
- A step coinciding with a mode-changing CTRL write: the mode change wins and the step is discarded.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronously).

Optional Feature:
- Macro: LED_SEQUENCER_PWM_EN.
- Defined:
  - Adds register 5 BRIGHT (rw, [3:0], reset 0xF).
  - A free-running 4-bit PWM counter, advancing every clk cycle, gates led.
  - Final led = seq_led & {5{pwm_cnt < BRIGHT}}, where BRIGHT=0xF means always on except pwm_cnt=15; BRIGHT=0 means off.
  - STATUS[4:0] reports the ungated seq_led.
  - The gating stage adds no extra latency: pwm_cnt compare and led register are in the same stage.
- Undefined: address 5 behaves as unused and led=seq_led.

Test Plan:
- Reset, then read addr 4 -> reg_ack exactly one cycle later; rdata=0x00. Then read addr 1 -> 0x01. Then read addr 2 -> 0xF4.
- TICK_DIV=4, write PERIOD=0x0002, CTRL=0x01 -> led sequence 01,02,04,08,10,01, changing every 8 clk; with CTRL=0x05 the sequence is 01,10,08,04,…
- Write PATTERN=0x15, CTRL=0x03, PERIOD=1, TICK_DIV=4 -> led alternates 0x15/0x00 every 4 clk, starting at 0x15 one cycle after the write ack.
- Simultaneous reg_we=1/reg_re=1 to addr 1 with wdata=0x0A -> single ack, PATTERN=0x0A, rdata unchanged. Write to addr 6 then read it -> 0x00, ack issued.
- In ROTATE with led=0x04, assert rst for 1 cycle between edges -> led=0 immediately. After release: CTRL=0 and led stays 0.
- With LED_SEQUENCER_PWM_EN: STATIC, PATTERN=0x1F, BRIGHT=4 -> led=0x1F for 4 of every 16 cycles, 0 for 12. Without the macro: read addr 5 returns 0x00.
